axis_sum_receiver: RTL and testbench

- AXI-Stream byte sink for the adder result stream.
- Consumes fixed-length result packets: BYTES bytes, most-significant byte first, TLAST on the final byte.
- Reassembles each packet into one parallel word and presents it on a valid/ready output port.
- Flags short and long framing errors and counts good packets; used as the scoreboard-facing end of the adder output interface.

---
 rtl/axis_sum_receiver_if.sv | 35 +++
 rtl/axis_sum_receiver.sv | 164 ++++++++++++++++
 tb/tb_axis_sum_receiver.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_sum_receiver_if.sv
// ---------------------------------------------------------------------------
// axis_sum_receiver_if
// Bundles the byte-stream input side and the reassembled-word output side of
// the adder result sink.
//   TDATA_in / TLAST_in / TVALID_in / TREADY_out : AXI-Stream byte input
//   SUM_out / SUM_valid / SUM_ready              : parallel word output
//   ERR_short / ERR_long                         : framing error pulses
//   PKT_count                                    : good-word counter
// slave  : the receiver (consumes the stream, drives the word port)
// master : the environment (drives the stream, consumes the word port)
// ---------------------------------------------------------------------------
interface axis_sum_receiver_if #(
  parameter int BYTES = 4
);
  logic [7:0]         TDATA_in;
  logic               TLAST_in;
  logic               TVALID_in;
  logic               TREADY_out;
  logic [8*BYTES-1:0] SUM_out;
  logic               SUM_valid;
  logic               SUM_ready;
  logic               ERR_short;
  logic               ERR_long;
  logic [15:0]        PKT_count;

  modport slave (
    input  TDATA_in, TLAST_in, TVALID_in, SUM_ready,
    output TREADY_out, SUM_out, SUM_valid, ERR_short, ERR_long, PKT_count
  );

  modport master (
    output TDATA_in, TLAST_in, TVALID_in, SUM_ready,
    input  TREADY_out, SUM_out, SUM_valid, ERR_short, ERR_long, PKT_count
  );
endinterface

// File: rtl/axis_sum_receiver.sv
// ---------------------------------------------------------------------------
// axis_sum_receiver
// AXI-Stream byte sink that reassembles fixed-length result packets (BYTES
// bytes, MSB first, TLAST on the final byte) into one parallel word held in
// a valid/ready output register. Short and long packets are dropped and
// flagged with one-cycle error pulses; good words are counted.
// Ports:
//   ACLK   : clock, rising edge
//   ARESET : synchronous reset, active-high
//   bus    : axis_sum_receiver_if.slave (stream in, word out, errors, count)
// ---------------------------------------------------------------------------
module axis_sum_receiver #(
  parameter int BYTES = 4
) (
  input  logic               ACLK,
  input  logic               ARESET,
  axis_sum_receiver_if.slave bus
);
  localparam int W     = 8 * BYTES;
  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  // Only the bytes preceding the current one are kept; the current byte is
  // appended combinationally so the final byte lands in the word directly.
  logic [W-9:0]     shreg_r;
  logic [W-1:0]     shifted_s;
  logic [W-1:0]     sum_r;
  logic             sum_valid_r;
  logic             err_short_r;
  logic             err_long_r;
  logic [15:0]      pkt_count_r;
  logic             at_last_s;
  logic             tready_s;
  logic             accept_s;
  logic             shift_s;
  logic             load_s;
  logic             short_s;
  logic             long_s;

  assign at_last_s = (cnt_r == CNT_LAST);
  assign accept_s  = bus.TVALID_in && tready_s;
  assign shifted_s = {shreg_r, bus.TDATA_in};

  // Stream ready: only the final byte waits, and only on a full, non-draining output register.
  always_comb begin
    tready_s = 1'b1;
    case (state_r)
      ST_COLLECT: tready_s = !(at_last_s && sum_valid_r && !bus.SUM_ready);
      ST_DISCARD: tready_s = 1'b1;
      default:    tready_s = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r <= ST_COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: enter DISCARD on an over-length packet, leave on its TLAST.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_COLLECT: begin
        if (accept_s && at_last_s && !bus.TLAST_in) begin
          state_nxt_s = ST_DISCARD;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_DISCARD: begin
        if (accept_s && bus.TLAST_in) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
      default: state_nxt_s = ST_COLLECT;
    endcase
  end

  // Output decode: byte counter update, word load and framing-error strobes.
  always_comb begin
    cnt_nxt_s = cnt_r;
    shift_s   = 1'b0;
    load_s    = 1'b0;
    short_s   = 1'b0;
    long_s    = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        if (accept_s) begin
          shift_s = 1'b1;
          if (at_last_s) begin
            cnt_nxt_s = '0;
            if (bus.TLAST_in) begin
              load_s = 1'b1;
            end else begin
              long_s = 1'b1;
            end
          end else if (bus.TLAST_in) begin
            cnt_nxt_s = '0;
            short_s   = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DISCARD: begin
        // Counter is already zero here; it is simply held for the next packet.
        cnt_nxt_s = '0;
      end
      default: cnt_nxt_s = '0;
    endcase
  end

  // Datapath registers: shift register, output word, error pulses and packet counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_r       <= '0;
      shreg_r     <= '0;
      sum_r       <= '0;
      sum_valid_r <= 1'b0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
      pkt_count_r <= 16'd0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      err_short_r <= short_s;
      err_long_r  <= long_s;
      if (shift_s) begin
        shreg_r <= shifted_s[W-9:0];
      end
      // A load wins over a drain so a simultaneous drain+load leaves no bubble.
      if (load_s) begin
        sum_r       <= shifted_s;
        sum_valid_r <= 1'b1;
        pkt_count_r <= pkt_count_r + 16'd1;
      end else if (bus.SUM_ready) begin
        sum_valid_r <= 1'b0;
      end
    end
  end

  assign bus.TREADY_out = tready_s;
  assign bus.SUM_out    = sum_r;
  assign bus.SUM_valid  = sum_valid_r;
  assign bus.ERR_short  = err_short_r;
  assign bus.ERR_long   = err_long_r;
  assign bus.PKT_count  = pkt_count_r;
endmodule

// File: tb/tb_axis_sum_receiver.sv
// ---------------------------------------------------------------------------
// tb_axis_sum_receiver
// Self-checking bench for axis_sum_receiver (BYTES=4). Directed scenarios plus
// a randomized packet stream compared against a packet-level reference model.
// ---------------------------------------------------------------------------
module tb_axis_sum_receiver;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axis_sum_receiver_if #(.BYTES(BYTES)) bus();

  axis_sum_receiver #(.BYTES(BYTES)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]   pkt_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int           mon_short    = 0;
  int           mon_long     = 0;
  int           mon_both     = 0;
  int           mon_unstable = 0;
  int           stall_cnt    = 0;
  bit           rand_ready   = 1'b0;
  bit           prev_hold    = 1'b0;
  logic [W-1:0] prev_out;

  // Observer: samples mid-cycle, records delivered words, pulses and hold violations.
  always @(negedge ACLK) begin
    #2;
    if (bus.ERR_short === 1'b1) mon_short++;
    if (bus.ERR_long === 1'b1) mon_long++;
    if (bus.ERR_short === 1'b1 && bus.ERR_long === 1'b1) mon_both++;
    if (prev_hold && (bus.SUM_out !== prev_out || bus.SUM_valid !== 1'b1)) mon_unstable++;
    if (bus.SUM_valid === 1'b1 && bus.SUM_ready === 1'b1) got_q.push_back(bus.SUM_out);
    prev_hold = (bus.SUM_valid === 1'b1) && (bus.SUM_ready === 1'b0) && (ARESET === 1'b0);
    prev_out  = bus.SUM_out;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < BYTES; k++) w = (w << 8) | W'(pkt_q[k]);
    return w;
  endfunction

  task automatic clear_mon();
    mon_short    = 0;
    mon_long     = 0;
    mon_both     = 0;
    mon_unstable = 0;
    stall_cnt    = 0;
    got_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ACLK);
      bus.TVALID_in = 1'b0;
      bus.TLAST_in  = 1'b0;
      if (rand_ready) bus.SUM_ready = ($urandom_range(1, 0) == 1);
    end
  endtask

  // Streams pkt_q; TLAST on the final byte only when last_flag is set.
  task automatic send_pkt(input int gap_pct, input bit last_flag);
    for (int i = 0; i < pkt_q.size(); i++) begin
      bit acc;
      int waitc;
      acc   = 1'b0;
      waitc = 0;
      while (!acc && waitc < 200) begin
        @(negedge ACLK);
        if (rand_ready) bus.SUM_ready = ($urandom_range(1, 0) == 1);
        bus.TVALID_in = ($urandom_range(99, 0) >= gap_pct);
        bus.TDATA_in  = pkt_q[i];
        bus.TLAST_in  = last_flag && (i == pkt_q.size() - 1);
        #1;
        acc = bus.TVALID_in && (bus.TREADY_out === 1'b1);
        if (bus.TVALID_in && bus.TREADY_out !== 1'b1) stall_cnt++;
        waitc++;
        @(posedge ACLK);
      end
      n_cmp++;
      if (!acc) begin
        n_fail++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted, got waits=%0d required <200", i, waitc);
      end
    end
  endtask

  task automatic test_reset();
    bus.TVALID_in = 1'b0;
    bus.TLAST_in  = 1'b0;
    bus.TDATA_in  = 8'h00;
    bus.SUM_ready = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    #3;
    n_cmp++; if (bus.TREADY_out !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b required 1", bus.TREADY_out); end
    n_cmp++; if (bus.SUM_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.SUM_valid); end
    n_cmp++; if (bus.SUM_out !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h required 0", bus.SUM_out); end
    n_cmp++; if (bus.PKT_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h required 0", bus.PKT_count); end
    n_cmp++; if (bus.ERR_short !== 1'b0 || bus.ERR_long !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b required 00", bus.ERR_short, bus.ERR_long); end
  endtask

  task automatic test_good_packet();
    logic [15:0] base;
    clear_mon();
    base  = bus.PKT_count;
    pkt_q = '{8'h00, 8'h00, 8'h01, 8'h2C};
    send_pkt(0, 1'b1);
    idle(1);
    #3;
    n_cmp++; if (bus.SUM_valid !== 1'b1) begin n_fail++; $display("FAIL good_latency_valid: got %b required 1", bus.SUM_valid); end
    n_cmp++; if (bus.SUM_out !== 32'h0000012C) begin n_fail++; $display("FAIL good_sum: got %h required 0000012c", bus.SUM_out); end
    idle(3);
    #3;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'h0000012C) begin n_fail++; $display("FAIL good_delivered: got %0d words required 1 of 0000012c", got_q.size()); end
    n_cmp++; if (bus.PKT_count !== base + 16'd1) begin n_fail++; $display("FAIL good_count: got %0d required %0d", bus.PKT_count, base + 16'd1); end
    n_cmp++; if (mon_short != 0 || mon_long != 0) begin n_fail++; $display("FAIL good_no_err: got short=%0d long=%0d required 0/0", mon_short, mon_long); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    clear_mon();
    base          = bus.PKT_count;
    bus.SUM_ready = 1'b0;
    pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(0, 1'b1);
    pkt_q = '{8'hAA, 8'hBB, 8'hCC};
    send_pkt(0, 1'b0);
    n_cmp++; if (stall_cnt != 0) begin n_fail++; $display("FAIL bp_overlap_stall: got %0d stalls required 0", stall_cnt); end
    @(negedge ACLK);
    bus.TVALID_in = 1'b1;
    bus.TDATA_in  = 8'hDD;
    bus.TLAST_in  = 1'b1;
    #1;
    n_cmp++; if (bus.TREADY_out !== 1'b0) begin n_fail++; $display("FAIL bp_last_stalled: got %b required 0", bus.TREADY_out); end
    repeat (2) begin
      @(posedge ACLK);
      @(negedge ACLK);
      #3;
      n_cmp++; if (bus.TREADY_out !== 1'b0) begin n_fail++; $display("FAIL bp_hold_tready: got %b required 0", bus.TREADY_out); end
      n_cmp++; if (bus.SUM_valid !== 1'b1 || bus.SUM_out !== 32'h11223344) begin n_fail++; $display("FAIL bp_hold_word: got %b/%h required 1/11223344", bus.SUM_valid, bus.SUM_out); end
    end
    @(negedge ACLK);
    bus.SUM_ready = 1'b1;
    #1;
    n_cmp++; if (bus.TREADY_out !== 1'b1) begin n_fail++; $display("FAIL bp_release_tready: got %b required 1", bus.TREADY_out); end
    @(posedge ACLK);
    idle(1);
    #3;
    n_cmp++; if (bus.SUM_valid !== 1'b1 || bus.SUM_out !== 32'hAABBCCDD) begin n_fail++; $display("FAIL bp_no_bubble: got %b/%h required 1/aabbccdd", bus.SUM_valid, bus.SUM_out); end
    n_cmp++; if (bus.PKT_count !== base + 16'd2) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", bus.PKT_count, base + 16'd2); end
    idle(3);
    #3;
    n_cmp++; if (got_q.size() != 2 || got_q[0] !== 32'h11223344 || got_q[1] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL bp_order: got %0d words required 2 (11223344,aabbccdd)", got_q.size()); end
    n_cmp++; if (mon_unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while held required 0", mon_unstable); end
  endtask

  task automatic test_short();
    clear_mon();
    bus.SUM_ready = 1'b1;
    pkt_q = '{8'h01, 8'h02, 8'h03};
    send_pkt(0, 1'b1);
    idle(1);
    #3;
    n_cmp++; if (bus.ERR_short !== 1'b1) begin n_fail++; $display("FAIL short_pulse: got %b required 1", bus.ERR_short); end
    idle(1);
    #3;
    n_cmp++; if (bus.ERR_short !== 1'b0) begin n_fail++; $display("FAIL short_one_cycle: got %b required 0", bus.ERR_short); end
    n_cmp++; if (bus.SUM_valid !== 1'b0) begin n_fail++; $display("FAIL short_no_valid: got %b required 0", bus.SUM_valid); end
    pkt_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(0, 1'b1);
    idle(3);
    #3;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL short_recover: got %0d words required 1 of deadbeef", got_q.size()); end
    n_cmp++; if (mon_short != 1 || mon_long != 0) begin n_fail++; $display("FAIL short_err_count: got short=%0d long=%0d required 1/0", mon_short, mon_long); end
  endtask

  task automatic test_long();
    logic [15:0] base;
    clear_mon();
    bus.SUM_ready = 1'b1;
    pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(0, 1'b0);
    idle(1);
    #3;
    n_cmp++; if (bus.ERR_long !== 1'b1) begin n_fail++; $display("FAIL long_pulse: got %b required 1", bus.ERR_long); end
    pkt_q = '{8'h05, 8'h06};
    send_pkt(0, 1'b1);
    n_cmp++; if (stall_cnt != 0) begin n_fail++; $display("FAIL long_discard_ready: got %0d stalls required 0", stall_cnt); end
    idle(2);
    #3;
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL long_no_word: got %0d words required 0", got_q.size()); end
    base  = bus.PKT_count;
    pkt_q = '{8'h00, 8'h00, 8'h00, 8'h05};
    send_pkt(0, 1'b1);
    idle(3);
    #3;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'h00000005) begin n_fail++; $display("FAIL long_recover: got %0d words required 1 of 00000005", got_q.size()); end
    n_cmp++; if (bus.PKT_count !== base + 16'd1) begin n_fail++; $display("FAIL long_count: got %0d required %0d", bus.PKT_count, base + 16'd1); end
    n_cmp++; if (mon_long != 1 || mon_short != 0) begin n_fail++; $display("FAIL long_err_count: got long=%0d short=%0d required 1/0", mon_long, mon_short); end
  endtask

  task automatic test_reset_mid();
    bus.SUM_ready = 1'b1;
    pkt_q = '{8'h09, 8'h08};
    send_pkt(0, 1'b0);
    @(negedge ACLK);
    bus.TVALID_in = 1'b0;
    ARESET        = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    clear_mon();
    pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(0, 1'b1);
    idle(3);
    #3;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'h01020304) begin n_fail++; $display("FAIL rstmid_word: got %0d words required 1 of 01020304", got_q.size()); end
    n_cmp++; if (mon_short != 0 || mon_long != 0) begin n_fail++; $display("FAIL rstmid_no_err: got short=%0d long=%0d required 0/0", mon_short, mon_long); end
    n_cmp++; if (bus.PKT_count !== 16'd1) begin n_fail++; $display("FAIL rstmid_count: got %0d required 1", bus.PKT_count); end
  endtask

  task automatic test_random_gaps();
    logic [W-1:0] exp_w;
    clear_mon();
    bus.SUM_ready = 1'b1;
    pkt_q = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    exp_w = model_word();
    send_pkt(50, 1'b1);
    idle(3);
    #3;
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== exp_w) begin n_fail++; $display("FAIL gaps_word: got %0d words required 1 of %h", got_q.size(), exp_w); end
    n_cmp++; if (mon_short != 0 || mon_long != 0) begin n_fail++; $display("FAIL gaps_no_err: got short=%0d long=%0d required 0/0", mon_short, mon_long); end
  endtask

  task automatic test_random_stream();
    logic [15:0] base;
    int exp_short;
    int exp_long;
    clear_mon();
    exp_q.delete();
    exp_short  = 0;
    exp_long   = 0;
    base       = bus.PKT_count;
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(BYTES + 3, 1);
      pkt_q.delete();
      for (int b = 0; b < len; b++) pkt_q.push_back(8'($urandom_range(255, 0)));
      if (len == BYTES) exp_q.push_back(model_word());
      else if (len < BYTES) exp_short++;
      else exp_long++;
      send_pkt($urandom_range(40, 0), 1'b1);
    end
    rand_ready = 1'b0;
    idle(1);
    bus.SUM_ready = 1'b1;
    idle(5);
    #3;
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_word_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_word[%0d]: got %h required %h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (mon_short != exp_short) begin n_fail++; $display("FAIL rand_short: got %0d required %0d", mon_short, exp_short); end
    n_cmp++; if (mon_long != exp_long) begin n_fail++; $display("FAIL rand_long: got %0d required %0d", mon_long, exp_long); end
    n_cmp++; if (bus.PKT_count !== 16'(base + exp_q.size())) begin n_fail++; $display("FAIL rand_count: got %0d required %0d", bus.PKT_count, 16'(base + exp_q.size())); end
    n_cmp++; if (mon_both != 0) begin n_fail++; $display("FAIL rand_err_exclusive: got %0d overlaps required 0", mon_both); end
    n_cmp++; if (mon_unstable != 0) begin n_fail++; $display("FAIL rand_stable: got %0d changes while held required 0", mon_unstable); end
  endtask

  initial begin
    ARESET        = 1'b0;
    bus.TVALID_in = 1'b0;
    bus.TLAST_in  = 1'b0;
    bus.TDATA_in  = 8'h00;
    bus.SUM_ready = 1'b1;
    test_reset();
    test_good_packet();
    test_back_to_back();
    test_short();
    test_long();
    test_reset_mid();
    test_random_gaps();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
